// File: rtl/dog_writer.sv
// dog_writer: streams two Gaussian BRAMs through a 2-cycle read pipeline and
// writes their signed per-pixel difference into a DoG BRAM.
module dog_writer #(
  parameter  int BIT_DEPTH = 8,
  parameter  int DIMENSION = 4,
  localparam int N         = DIMENSION * DIMENSION,
  localparam int AW        = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 enable,
  output logic [AW-1:0]        first_address,
  input  logic [BIT_DEPTH-1:0] first_data,
  output logic [AW-1:0]        second_address,
  input  logic [BIT_DEPTH-1:0] second_data,
  output logic [AW-1:0]        dog_address,
  output logic [BIT_DEPTH:0]   dog_data,
  output logic                 dog_we,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t                r_state, w_next;
  logic [AW-1:0]         r_addr, w_addr_n, r_a0, r_a1, r_waddr;
  logic [1:0]            r_v;
  logic [BIT_DEPTH:0]    r_wdata;
  logic                  r_we, r_done, w_last;
  assign w_last = r_addr == AW'(N - 1);
  always_ff @(posedge clk or negedge rst_in)
    if (!rst_in) r_state <= IDLE;
    else         r_state <= w_next;
  // DRAIN ends once the last read has left the second pipeline stage
  always_comb begin
    w_next   = r_state;
    w_addr_n = '0;
    if (r_state == IDLE) w_next = enable ? READ : IDLE;
    if (r_state == READ) begin
      w_next   = w_last ? DRAIN : READ;
      w_addr_n = w_last ? r_addr : r_addr + AW'(1);
    end
    if (r_state == DRAIN) begin
      w_next   = r_v[1] ? DRAIN : IDLE;
      w_addr_n = r_addr;
    end
  end
  always_ff @(posedge clk or negedge rst_in)
    if (!rst_in) begin
      r_addr  <= '0;
      r_v     <= '0;
      r_a0    <= '0;
      r_a1    <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_addr  <= w_addr_n;
      r_v     <= {r_v[0], r_state == READ};
      r_a0    <= r_addr;
      r_a1    <= r_a0;
      r_we    <= r_v[1];
      r_waddr <= r_a1;
      r_wdata <= {1'b0, first_data} - {1'b0, second_data};
      r_done  <= r_state == DRAIN && w_next == IDLE;
    end
  assign first_address  = r_addr;
  assign second_address = r_addr;
  assign dog_address    = r_waddr;
  assign dog_data       = r_wdata;
  assign dog_we         = r_we;
  assign busy           = r_state != IDLE;
  assign done           = r_done;
endmodule

// File: tb/tb_dog_writer.sv
// tb_dog_writer: scoreboard bench with 2-cycle source BRAM models, a DoG BRAM
// model and a per-cycle busy/done/write timing reference.
module tb_dog_writer;
  localparam int N  = 16;
  localparam int AW = 4;
  logic          clk = 1'b0;
  logic          rst_in, enable;
  logic [AW-1:0] first_address, second_address, dog_address;
  logic [7:0]    first_data, second_data, p1, p2;
  logic [8:0]    dog_data;
  logic          dog_we, busy, done;
  logic [7:0]    m1 [N];
  logic [7:0]    m2 [N];
  logic [8:0]    dmem [N];
  int            qa[$], qd[$];
  int            ph, n_chk, n_err, wcnt, dcnt, base;
  bit            hit;

  dog_writer dut (
    .clk(clk), .rst_in(rst_in), .enable(enable),
    .first_address(first_address), .first_data(first_data),
    .second_address(second_address), .second_data(second_data),
    .dog_address(dog_address), .dog_data(dog_data), .dog_we(dog_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_diff(input int a, input int b);
    logic [8:0] d;
    d = 9'(a) - 9'(b);
    return int'(d);
  endfunction

  always @(posedge clk) begin
    p1 <= m1[first_address];
    p2 <= m2[second_address];
    first_data  <= p1;
    second_data <= p2;
    if (dog_we && rst_in) dmem[dog_address] <= dog_data;
  end

  // ph = cycles since the accepted enable; 0 means idle
  always @(posedge clk or negedge rst_in)
    if (!rst_in) begin
      ph <= 0;
      qa.delete();
      qd.delete();
    end else if ((ph == 0 || ph == N + 4) && enable) begin
      ph <= 1;
      for (int i = 0; i < N; i++) begin
        qa.push_back(i);
        qd.push_back(ref_diff(int'(m1[i]), int'(m2[i])));
      end
    end else if (ph != 0 && ph < N + 4) ph <= ph + 1;
    else ph <= 0;

  always @(negedge clk)
    if (rst_in) begin
      chk("busy", int'(busy), int'(ph >= 1 && ph <= N + 3));
      chk("done", int'(done), int'(ph == N + 4));
      chk("we", int'(dog_we), int'(ph >= 4 && ph <= N + 3));
      if (ph >= 1 && ph <= N + 3) begin
        chk("raddr1", int'(first_address), ph <= N ? ph - 1 : N - 1);
        chk("raddr2", int'(second_address), ph <= N ? ph - 1 : N - 1);
      end
      if (done) dcnt++;
      if (dog_we) begin
        wcnt++;
        if (qa.size() == 0) chk("sb_empty", 1, 0);
        else begin
          chk("waddr", int'(dog_address), qa.pop_front());
          chk("wdata", int'(dog_data), qd.pop_front());
        end
      end
    end

  task automatic pulse();
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < N; i++) begin
      m1[i] = 8'(10 * i);
      m2[i] = 8'd5;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_we", int'(dog_we), 0);
    chk("rst_addr", int'(first_address), 0);
    chk("rst_waddr", int'(dog_address), 0);
    chk("rst_wdata", int'(dog_data), 0);
    rst_in = 1'b1;
    repeat (2) @(negedge clk);
    pulse();
    repeat (N + 6) @(negedge clk);
    for (int i = 0; i < N; i++) chk("ramp_mem", int'($signed(dmem[i])), 10 * i - 5);
    for (int i = 0; i < N; i++) begin
      m1[i] = 8'($urandom_range(255));
      m2[i] = 8'($urandom_range(255));
    end
    m1[3] = 8'd0;
    m2[3] = 8'd255;
    m1[7] = 8'd255;
    m2[7] = 8'd0;
    pulse();
    repeat (N + 6) @(negedge clk);
    chk("ext_min", int'(dmem[3]), 'h101);
    chk("ext_max", int'(dmem[7]), 'h0FF);
    for (int i = 0; i < N; i++) chk("ext_mem", int'(dmem[i]), ref_diff(int'(m1[i]), int'(m2[i])));
    wcnt = 0;
    dcnt = 0;
    @(negedge clk) enable = 1'b1;
    repeat (N + 6) @(negedge clk);
    enable = 1'b0;
    repeat (N + 8) @(negedge clk);
    chk("hold_writes", wcnt, 2 * N);
    chk("hold_dones", dcnt, 2);
    wcnt = 0;
    pulse();
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = done;
    end
    if (!hit) chk("b2b_timeout", 0, 1);
    enable = 1'b1;
    @(negedge clk) enable = 1'b0;
    repeat (N + 6) @(negedge clk);
    chk("b2b_writes", wcnt, 2 * N);
    pulse();
    repeat (8) @(posedge clk);
    #2 rst_in = 1'b0;
    #1;
    chk("abort_we", int'(dog_we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    base = wcnt;
    repeat (2) @(negedge clk);
    rst_in = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_quiet", wcnt, base);
    pulse();
    repeat (N + 6) @(negedge clk);
    chk("fresh_writes", wcnt, base + N);
    chk("sb_left", qa.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
